// File: rtl/spram_2048_40bit_ctrl_pkg.sv
// Shared sizing defaults, FSM encoding and requester IDs for the SPRAM controller.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package spram_2048_40bit_ctrl_pkg;

  localparam int DEF_AWIDTH    = 11;
  localparam int DEF_NUM_WORDS = 2048;
  localparam int DEF_DWIDTH    = 40;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INIT = 1'b1
  } state_t;

  // Requester IDs, also used as the round-robin last_grant encoding.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/spram_2048_40bit.sv
// Behavioural 2048x40 single-port RAM macro with a registered read port.
// Latency: read data appears one cycle after a read access; writes commit at the edge.
// Backpressure: none; one access per enabled cycle, out register holds when not reading.
module spram_2048_40bit
  import spram_2048_40bit_ctrl_pkg::*;
#(
  parameter int AWIDTH    = DEF_AWIDTH,
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int DWIDTH    = DEF_DWIDTH
) (
  input  logic              clk,
  input  logic              ce,
  input  logic              we,
  input  logic [AWIDTH-1:0] addr,
  input  logic [DWIDTH-1:0] wdata,
  output logic [DWIDTH-1:0] rdata
);

  logic [DWIDTH-1:0] mem [NUM_WORDS];

  // Array write or registered read; the out register only changes on a read access.
  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/spram_2048_40bit_ctrl_arb.sv
// Two-way round-robin arbiter with a combinational grant.
// Latency: grant in the same cycle as the request; last_grant updates at the grant edge.
// Backpressure: a losing or disabled requester sees no grant and must hold its request.
module spram_rr_arb2
  import spram_2048_40bit_ctrl_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic enable,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic last_grant;

  // Grant the sole requester, or on contention the one not served last.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (enable) begin
      if (req0 && (!req1 || (last_grant == REQ1))) begin
        gnt0 = 1'b1;
      end else if (req1) begin
        gnt1 = 1'b1;
      end
    end
  end

  // Remember who was served; reset state lets requester 0 win the first tie.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_grant <= REQ1;
    end else if (gnt0) begin
      last_grant <= REQ0;
    end else if (gnt1) begin
      last_grant <= REQ1;
    end
  end

endmodule

// File: rtl/spram_2048_40bit_ctrl.sv
// Shares one 2048x40 SPRAM between two requesters, with a zero-fill init engine.
// Latency: grant same cycle as req; read data + rvalid one cycle after the read grant.
// Backpressure: requesters hold req until granted; no grants at all while zero-filling.
module spram_2048_40bit_ctrl
  import spram_2048_40bit_ctrl_pkg::*;
#(
  parameter int AWIDTH    = DEF_AWIDTH,
  parameter int NUM_WORDS = DEF_NUM_WORDS,
  parameter int DWIDTH    = DEF_DWIDTH
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [AWIDTH-1:0] addr0,
  input  logic [AWIDTH-1:0] addr1,
  input  logic [DWIDTH-1:0] wdata0,
  input  logic [DWIDTH-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DWIDTH-1:0] rdata
);

  localparam logic [AWIDTH-1:0] LAST_ADDR = AWIDTH'(NUM_WORDS - 1);

  state_t            state, state_nxt;
  logic [AWIDTH-1:0] cnt, cnt_nxt;
  logic              done_nxt;
  logic              arb_en;
  logic              ram_ce, ram_we;
  logic [AWIDTH-1:0] ram_addr, addr_q;
  logic [DWIDTH-1:0] ram_wdata;

  assign init_busy = (state == ST_INIT);
  // Grants are only possible while serving and never while reset is asserted.
  assign arb_en    = resetn && (state == ST_IDLE);

  spram_rr_arb2 u_arb (
    .clk    (clk),
    .resetn (resetn),
    .enable (arb_en),
    .req0   (req0),
    .req1   (req1),
    .gnt0   (gnt0),
    .gnt1   (gnt1)
  );

  // FSM state, init counter and the done pulse register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      init_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      init_done <= done_nxt;
    end
  end

  // Next state: IDLE waits for init_start; INIT sweeps the counter and stops after the last word.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    done_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (init_start) begin
          state_nxt = ST_INIT;
        end
      end
      ST_INIT: begin
        if (cnt == LAST_ADDR) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          done_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + AWIDTH'(1);
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // RAM port mux: init engine, else the granted requester, else hold the last address.
  always_comb begin
    ram_ce    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = addr_q;
    ram_wdata = '0;
    if (state == ST_INIT) begin
      ram_ce   = 1'b1;
      ram_we   = 1'b1;
      ram_addr = cnt;
    end else if (gnt0) begin
      ram_ce    = 1'b1;
      ram_we    = we0;
      ram_addr  = addr0;
      ram_wdata = wdata0;
    end else if (gnt1) begin
      ram_ce    = 1'b1;
      ram_we    = we1;
      ram_addr  = addr1;
      ram_wdata = wdata1;
    end
  end

  // Address hold register so an idle cycle keeps presenting the previous address.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_q <= '0;
    end else begin
      addr_q <= ram_addr;
    end
  end

  // Read-return pipeline: one pulse per granted read, steered to the requester that issued it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
    end else begin
      rvalid0 <= gnt0 && !we0;
      rvalid1 <= gnt1 && !we1;
    end
  end

  spram_2048_40bit #(
    .AWIDTH    (AWIDTH),
    .NUM_WORDS (NUM_WORDS),
    .DWIDTH    (DWIDTH)
  ) u_ram (
    .clk   (clk),
    .ce    (ram_ce),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_spram_2048_40bit_ctrl.sv
// Directed bench for the shared SPRAM controller: handshake, arbitration, init engine, resets.
// Latency: checks grant same cycle and read return one cycle later.
// Backpressure: checks that requests stall for the whole zero-fill.
module tb_spram_2048_40bit_ctrl;

  localparam int AW = 11;
  localparam int DW = 40;

  logic          clk = 1'b0;
  logic          resetn;
  logic          init_start;
  logic          init_busy, init_done;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata;

  int total = 0;
  int bad   = 0;

  spram_2048_40bit_ctrl dut (
    .clk        (clk),
    .resetn     (resetn),
    .init_start (init_start),
    .init_busy  (init_busy),
    .init_done  (init_done),
    .req0       (req0),
    .req1       (req1),
    .we0        (we0),
    .we1        (we1),
    .addr0      (addr0),
    .addr1      (addr1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .gnt0       (gnt0),
    .gnt1       (gnt1),
    .rvalid0    (rvalid0),
    .rvalid1    (rvalid1),
    .rdata      (rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse init_start, then watch the sweep with a bounded loop.
  task automatic run_init(input int hold_lo, input int hold_hi, input int req_at,
                          output int busy, output int done_cnt, output int saw_gnt,
                          output logic gnt_at_done, output logic rv_after,
                          output logic [DW-1:0] rd_after);
    step();
    init_start = 1'b1;
    @(negedge clk);
    busy = 0; done_cnt = 0; saw_gnt = 0; gnt_at_done = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      step();
      init_start = (c >= hold_lo) && (c < hold_hi);
      if (c == req_at) begin
        req1 = 1'b1; we1 = 1'b0; addr1 = 11'd1000;
      end
      @(negedge clk);
      if (init_busy) busy++;
      if (init_busy && (gnt0 || gnt1)) saw_gnt = 1;
      if (init_done) begin
        done_cnt++;
        gnt_at_done = gnt1;
        break;
      end
    end
    step();
    init_start = 1'b0;
    req1 = 1'b0;
    @(negedge clk);
    if (init_done) done_cnt++;
    rv_after = rvalid1;
    rd_after = rdata;
  endtask

  int busy_n, done_n, gnt_seen, late_done;
  logic gd, rv;
  logic [DW-1:0] rd;
  logic [DW-1:0] va, vb;

  initial begin
    resetn = 1'b0; init_start = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
    va = 40'h00_AAAA_0010;
    vb = 40'h00_BBBB_0020;

    // Reset state, with a request pending to show the grant is forced low.
    repeat (3) step();
    @(negedge clk);
    chk("rst_gnt0", gnt0, 0);
    chk("rst_rvalid0", rvalid0, 0);
    chk("rst_rvalid1", rvalid1, 0);
    chk("rst_busy", init_busy, 0);
    chk("rst_done", init_done, 0);

    // Single write then read of addr 5 by requester 0.
    step();
    resetn = 1'b1; req0 = 1'b1; we0 = 1'b1; addr0 = 11'd5; wdata0 = 40'h12_3456_789A;
    @(negedge clk);
    chk("wr5_gnt0", gnt0, 1);
    chk("wr5_gnt1", gnt1, 0);
    step();
    we0 = 1'b0;
    @(negedge clk);
    chk("rd5_gnt0", gnt0, 1);
    chk("rd5_no_early_rvalid", rvalid0, 0);
    step();
    req0 = 1'b0;
    @(negedge clk);
    chk("rd5_rvalid0", rvalid0, 1);
    chk("rd5_rdata", rdata, 40'h12_3456_789A);
    chk("rd5_rvalid1", rvalid1, 0);

    // Write by requester 0, read back by requester 1 in the very next cycle.
    step();
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'd7; wdata0 = 40'hAA;
    @(negedge clk);
    chk("b2b_gnt0", gnt0, 1);
    step();
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 11'd7;
    @(negedge clk);
    chk("b2b_gnt1", gnt1, 1);
    step();
    req1 = 1'b0;
    @(negedge clk);
    chk("b2b_rvalid1", rvalid1, 1);
    chk("b2b_rdata", rdata, 40'hAA);

    // Contention: preload two words, then both read for 6 cycles.
    step();
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'd10; wdata0 = va;
    @(negedge clk);
    step();
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b1; addr1 = 11'd20; wdata1 = vb;
    @(negedge clk);
    step();
    req0 = 1'b1; we0 = 1'b0; req1 = 1'b1; we1 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("rr_gnt0_%0d", i), gnt0, (i % 2) == 0);
      chk($sformatf("rr_gnt1_%0d", i), gnt1, (i % 2) == 1);
      if (i > 0) begin
        chk($sformatf("rr_rvalid0_%0d", i), rvalid0, ((i - 1) % 2) == 0);
        chk($sformatf("rr_rdata_%0d", i), rdata, ((i - 1) % 2) == 0 ? va : vb);
      end
      step();
    end
    req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("rr_last_rvalid1", rvalid1, 1);
    chk("rr_last_rdata", rdata, vb);

    // Preload the first, a middle and the last word, then zero-fill.
    step();
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'd0; wdata0 = 40'h11;
    step();
    addr0 = 11'd1000; wdata0 = 40'h22;
    step();
    addr0 = 11'd2047; wdata0 = 40'h33;
    step();
    req0 = 1'b0; we0 = 1'b0;
    run_init(-1, -1, -1, busy_n, done_n, gnt_seen, gd, rv, rd);
    chk("init_busy_cycles", busy_n, 2048);
    chk("init_done_pulses", done_n, 1);

    step();
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'd0;
    step();
    addr0 = 11'd1000;
    @(negedge clk);
    chk("clr0_rvalid", rvalid0, 1);
    chk("clr0_rdata", rdata, 0);
    step();
    addr0 = 11'd2047;
    @(negedge clk);
    chk("clr1000_rdata", rdata, 0);
    step();
    req0 = 1'b0;
    @(negedge clk);
    chk("clr2047_rvalid", rvalid0, 1);
    chk("clr2047_rdata", rdata, 0);

    // Stall: req1 read asserted mid-sweep, init_start held high for most of it.
    step();
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'd1000; wdata0 = 40'h44;
    step();
    req0 = 1'b0;
    run_init(10, 2000, 50, busy_n, done_n, gnt_seen, gd, rv, rd);
    chk("stall_busy_cycles", busy_n, 2048);
    chk("stall_done_pulses", done_n, 1);
    chk("stall_no_gnt_in_init", gnt_seen, 0);
    chk("stall_gnt1_after", gd, 1);
    chk("stall_rvalid1", rv, 1);
    chk("stall_rdata", rd, 0);

    // Reset in cycle 100 of a sweep.
    step();
    init_start = 1'b1;
    step();
    init_start = 1'b0;
    repeat (100) step();
    resetn = 1'b0; req0 = 1'b1; we0 = 1'b0; req1 = 1'b1; we1 = 1'b0;
    @(negedge clk);
    chk("midrst_busy_before", init_busy, 1);
    step();
    resetn = 1'b1; req0 = 1'b0; req1 = 1'b0;
    @(negedge clk);
    chk("midrst_busy", init_busy, 0);
    chk("midrst_gnt0", gnt0, 0);
    chk("midrst_gnt1", gnt1, 0);
    chk("midrst_rvalid0", rvalid0, 0);
    chk("midrst_rvalid1", rvalid1, 0);
    late_done = 0;
    for (int i = 0; i < 2100; i++) begin
      if (init_done) late_done++;
      step();
      @(negedge clk);
    end
    chk("midrst_no_done", late_done, 0);

    run_init(-1, -1, -1, busy_n, done_n, gnt_seen, gd, rv, rd);
    chk("reinit_busy_cycles", busy_n, 2048);
    chk("reinit_done_pulses", done_n, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
